// File: rtl/traffic_phase_sequencer_pkg.sv
// Shared definitions for the intersection phase sequencer: phase state
// encoding and lamp one-hot patterns {red, yellow, green}.
package traffic_phase_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_INIT      = 3'd0,
    ST_NS_GREEN  = 3'd1,
    ST_NS_YELLOW = 3'd2,
    ST_ALL_RED_1 = 3'd3,
    ST_EW_GREEN  = 3'd4,
    ST_EW_YELLOW = 3'd5,
    ST_ALL_RED_2 = 3'd6,
    ST_EMG       = 3'd7
  } phase_e;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

endpackage

// File: rtl/traffic_phase_sequencer_light_decoder.sv
// Pure decode of the current phase into north-south / east-west lamp drives.
// Only the four green/yellow phases light anything other than red, and each
// of those lights exactly one direction, so both directions can never be
// non-red at the same time.
module light_decoder
  import traffic_phase_sequencer_pkg::*;
(
  input  phase_e     phase_i,
  output logic [2:0] ns_light_o,
  output logic [2:0] ew_light_o
);

  // Map each phase to its lamp pattern; anything unlisted is all-red.
  always_comb begin
    ns_light_o = LAMP_RED;
    ew_light_o = LAMP_RED;
    case (phase_i)
      ST_NS_GREEN:  ns_light_o = LAMP_GRN;
      ST_NS_YELLOW: ns_light_o = LAMP_YEL;
      ST_EW_GREEN:  ew_light_o = LAMP_GRN;
      ST_EW_YELLOW: ew_light_o = LAMP_YEL;
      default: begin
        ns_light_o = LAMP_RED;
        ew_light_o = LAMP_RED;
      end
    endcase
  end

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Intersection phase sequencer. Commands an external saturating countdown
// timer (down / forced load / load value) and reacts to its zero flag.
// The load value always names the duration of the phase that would be
// entered on zero, so a timer reload lands on the same edge as the phase
// change. Emergency requests are latched so a request seen during a
// non-preemptible yellow is honoured once the yellow ends.
module traffic_phase_sequencer
  import traffic_phase_sequencer_pkg::*;
#(
  parameter int unsigned BIT_WIDTH  = 7,
  parameter int unsigned T_GREEN_NS = 20,
  parameter int unsigned T_GREEN_EW = 15,
  parameter int unsigned T_YELLOW   = 4,
  parameter int unsigned T_CLEAR    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tmr_zero,
  input  logic                 emg_req,
  input  logic                 ew_sense,
  output logic                 tmr_down,
  output logic                 tmr_emg_load,
  output logic [BIT_WIDTH-1:0] tmr_load_value,
  output logic [2:0]           ns_light,
  output logic [2:0]           ew_light,
  output logic [2:0]           phase
);

  localparam logic [BIT_WIDTH-1:0] LD_GREEN_NS = BIT_WIDTH'(T_GREEN_NS);
  localparam logic [BIT_WIDTH-1:0] LD_GREEN_EW = BIT_WIDTH'(T_GREEN_EW);
  localparam logic [BIT_WIDTH-1:0] LD_YELLOW   = BIT_WIDTH'(T_YELLOW);
  localparam logic [BIT_WIDTH-1:0] LD_CLEAR    = BIT_WIDTH'(T_CLEAR);

  phase_e state_q, state_d;
  logic   emg_pend_q, emg_pend_d;
  logic   ew_dem_q, ew_dem_d;
  logic   emg_act;

  assign emg_act  = emg_req | emg_pend_q;
  assign tmr_down = (state_q != ST_INIT);
  assign phase    = state_q;

  // State and request latches; reset returns to INIT with latches cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      emg_pend_q <= 1'b0;
      ew_dem_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      emg_pend_q <= emg_pend_d;
      ew_dem_q   <= ew_dem_d;
    end
  end

  // Next phase, forced-load pulse and the duration of the phase entered on zero.
  always_comb begin
    state_d        = state_q;
    tmr_emg_load   = 1'b0;
    tmr_load_value = LD_CLEAR;
    case (state_q)
      ST_INIT: begin
        // tmr_down is low here, so the timer loads the clearance time.
        state_d        = ST_ALL_RED_2;
        tmr_load_value = LD_CLEAR;
      end
      ST_NS_GREEN, ST_EW_GREEN: begin
        tmr_load_value = LD_YELLOW;
        if (emg_act) begin
          state_d      = (state_q == ST_NS_GREEN) ? ST_NS_YELLOW : ST_EW_YELLOW;
          tmr_emg_load = 1'b1;
        end else if (tmr_zero) begin
          state_d = (state_q == ST_NS_GREEN) ? ST_NS_YELLOW : ST_EW_YELLOW;
        end else begin
          state_d = state_q;
        end
      end
      ST_NS_YELLOW, ST_EW_YELLOW: begin
        // Yellow always runs to completion; emergency only redirects the exit.
        tmr_load_value = LD_CLEAR;
        if (tmr_zero) begin
          if (emg_act) begin
            state_d = ST_EMG;
          end else begin
            state_d = (state_q == ST_NS_YELLOW) ? ST_ALL_RED_1 : ST_ALL_RED_2;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_ALL_RED_1, ST_ALL_RED_2: begin
        if (emg_act) begin
          state_d        = ST_EMG;
          tmr_emg_load   = 1'b1;
          tmr_load_value = LD_CLEAR;
        end else if ((state_q == ST_ALL_RED_1) && ew_dem_q) begin
          tmr_load_value = LD_GREEN_EW;
          state_d        = tmr_zero ? ST_EW_GREEN : state_q;
        end else begin
          tmr_load_value = LD_GREEN_NS;
          state_d        = tmr_zero ? ST_NS_GREEN : state_q;
        end
      end
      ST_EMG: begin
        if (emg_req) begin
          // Hold: keep reloading the release time while the request is up.
          tmr_emg_load   = 1'b1;
          tmr_load_value = LD_CLEAR;
          state_d        = ST_EMG;
        end else begin
          tmr_load_value = LD_GREEN_NS;
          state_d        = tmr_zero ? ST_NS_GREEN : ST_EMG;
        end
      end
      default: begin
        state_d        = ST_INIT;
        tmr_emg_load   = 1'b0;
        tmr_load_value = LD_CLEAR;
      end
    endcase
  end

  // Request latches; a clear on the entering edge beats a concurrent set.
  always_comb begin
    emg_pend_d = emg_pend_q;
    ew_dem_d   = ew_dem_q;
    if ((state_d == ST_EMG) && (state_q != ST_EMG)) begin
      emg_pend_d = 1'b0;
    end else if (emg_req && (state_q != ST_EMG)) begin
      emg_pend_d = 1'b1;
    end else begin
      emg_pend_d = emg_pend_q;
    end
    if ((state_d == ST_EW_GREEN) && (state_q != ST_EW_GREEN)) begin
      ew_dem_d = 1'b0;
    end else if (ew_sense) begin
      ew_dem_d = 1'b1;
    end else begin
      ew_dem_d = ew_dem_q;
    end
  end

  light_decoder u_light_decoder (
    .phase_i    (state_q),
    .ns_light_o (ns_light),
    .ew_light_o (ew_light)
  );

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Bench for traffic_phase_sequencer: attaches a countdown timer model,
// keeps a duration-based phase model (a phase of duration D lasts D+1
// cycles) and compares every cycle, plus literal phase checkpoints.
module tb_traffic_phase_sequencer;

  localparam int P_INIT = 0, P_NSG = 1, P_NSY = 2, P_AR1 = 3;
  localparam int P_EWG  = 4, P_EWY = 5, P_AR2 = 6, P_EMG = 7;
  localparam int D_NS = 20, D_EW = 15, D_Y = 4, D_C = 2;

  logic       clk = 1'b0;
  logic       rst, tmr_zero, emg_req, ew_sense;
  logic       tmr_down, tmr_emg_load;
  logic [6:0] tmr_load_value;
  logic [2:0] ns_light, ew_light, phase;

  logic [6:0] tmr_q = 7'd0;
  int m_phase = 0, m_age = 0;
  bit m_pend = 1'b0, m_dem = 1'b0;
  bit chk_en = 1'b0;
  int total = 0, bad = 0;
  int cyc = 0;

  traffic_phase_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .tmr_zero       (tmr_zero),
    .emg_req        (emg_req),
    .ew_sense       (ew_sense),
    .tmr_down       (tmr_down),
    .tmr_emg_load   (tmr_emg_load),
    .tmr_load_value (tmr_load_value),
    .ns_light       (ns_light),
    .ew_light       (ew_light),
    .phase          (phase)
  );

  always #5 clk = ~clk;

  // External saturating countdown timer.
  assign tmr_zero = (tmr_q == 7'd0);
  always @(posedge clk) begin
    if (!tmr_down || tmr_emg_load || tmr_q == 7'd0) tmr_q <= tmr_load_value;
    else tmr_q <= tmr_q - 7'd1;
  end

  function automatic int dur_of(input int p);
    case (p)
      P_NSG: return D_NS;
      P_EWG: return D_EW;
      P_NSY, P_EWY: return D_Y;
      P_AR1, P_AR2, P_EMG: return D_C;
      default: return 0;
    endcase
  endfunction

  // Phase reached from p after one edge, given whether the phase time is up.
  function automatic int next_of(input int p, input bit zero, input bit req,
                                 input bit act, input bit dem);
    if (p == P_INIT) return P_AR2;
    if (p == P_EMG) return (!req && zero) ? P_NSG : P_EMG;
    if (p == P_NSG || p == P_EWG) return (act || zero) ? p + 1 : p;
    if (p == P_NSY || p == P_EWY) begin
      if (!zero) return p;
      if (act) return P_EMG;
      return (p == P_NSY) ? P_AR1 : P_AR2;
    end
    if (act) return P_EMG;
    if (!zero) return p;
    return (p == P_AR1 && dem) ? P_EWG : P_NSG;
  endfunction

  function automatic int ns_of(input int p);
    return (p == P_NSG) ? 1 : (p == P_NSY) ? 2 : 4;
  endfunction

  function automatic int ew_of(input int p);
    return (p == P_EWG) ? 1 : (p == P_EWY) ? 2 : 4;
  endfunction

  // Behavioural model step.
  always @(posedge clk) begin
    int np;
    if (rst) begin
      m_phase <= P_INIT;
      m_pend  <= 1'b0;
      m_dem   <= 1'b0;
      m_age   <= 0;
    end else begin
      np = next_of(m_phase, m_age == dur_of(m_phase), emg_req,
                   emg_req | m_pend, m_dem);
      if (np == P_EMG && m_phase != P_EMG) m_pend <= 1'b0;
      else if (emg_req && m_phase != P_EMG) m_pend <= 1'b1;
      if (np == P_EWG && m_phase != P_EWG) m_dem <= 1'b0;
      else if (ew_sense) m_dem <= 1'b1;
      if (np != m_phase || (m_phase == P_EMG && emg_req)) m_age <= 0;
      else m_age <= m_age + 1;
      m_phase <= np;
    end
  end

  task automatic check(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      int nz, n0;
      bit act;
      act = emg_req | m_pend;
      nz  = next_of(m_phase, 1'b1, emg_req, act, m_dem);
      n0  = next_of(m_phase, 1'b0, emg_req, act, m_dem);
      check("phase", int'(phase), m_phase);
      check("tmr_down", int'(tmr_down), (m_phase != P_INIT) ? 1 : 0);
      check("load_value", int'(tmr_load_value), dur_of(nz));
      check("emg_load", int'(tmr_emg_load),
            (m_phase != P_INIT && (n0 != m_phase || (m_phase == P_EMG && emg_req))) ? 1 : 0);
      check("ns_light", int'(ns_light), ns_of(m_phase));
      check("ew_light", int'(ew_light), ew_of(m_phase));
      check("ns_onehot", $countones(ns_light), 1);
      check("ew_onehot", $countones(ew_light), 1);
      check("safety", (ns_light != 3'b100 && ew_light != 3'b100) ? 1 : 0, 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic lit(input string nm, input int at, input int exp);
    run_to(at);
    check({nm, "_dut"}, int'(phase), exp);
    check({nm, "_model"}, m_phase, exp);
  endtask

  initial begin
    rst = 1'b1; emg_req = 1'b0; ew_sense = 1'b0;
    step();
    chk_en = 1'b1;
    step(); step();
    rst = 1'b0;
    cyc = 0;
    // Idle cycle, no east-west demand.
    check("c0_phase", int'(phase), P_INIT);
    check("c0_down", int'(tmr_down), 0);
    check("c0_load", int'(tmr_load_value), 2);
    lit("c1", 1, P_AR2);   lit("c3", 3, P_AR2);
    lit("c4", 4, P_NSG);   lit("c24", 24, P_NSG);
    lit("c25", 25, P_NSY); lit("c29", 29, P_NSY);
    lit("c30", 30, P_AR1); lit("c32", 32, P_AR1);
    lit("c33_skip_ew", 33, P_NSG);
    // East-west demand pulse.
    run_to(40); ew_sense = 1'b1; step(); ew_sense = 1'b0;
    lit("c61", 61, P_AR1); lit("c62", 62, P_EWG); lit("c77", 77, P_EWG);
    lit("c78", 78, P_EWY); lit("c82", 82, P_EWY);
    lit("c83", 83, P_AR2); lit("c85", 85, P_AR2); lit("c86", 86, P_NSG);
    // Emergency preempts green.
    run_to(94);
    check("c94_timer", int'(tmr_q), 12);
    emg_req = 1'b1; #1;
    check("c94_emg_load", int'(tmr_emg_load), 1);
    step(); emg_req = 1'b0; #1;
    check("c95_phase", int'(phase), P_NSY);
    check("c95_timer", int'(tmr_q), 4);
    check("c95_emg_load", int'(tmr_emg_load), 0);
    lit("c99", 99, P_NSY); lit("c100", 100, P_EMG);
    lit("c102", 102, P_EMG); lit("c103", 103, P_NSG);
    // Emergency held through yellow and 10 cycles of EMG.
    emg_req = 1'b1;
    lit("c108", 108, P_NSY);
    for (int i = 109; i <= 118; i++) begin
      run_to(i);
      check("hold_phase", int'(phase), P_EMG);
      check("hold_emg_load", int'(tmr_emg_load), 1);
      check("hold_timer", int'(tmr_q), 2);
      check("hold_ns_red", int'(ns_light), 4);
      check("hold_ew_red", int'(ew_light), 4);
    end
    run_to(119); emg_req = 1'b0;
    lit("c121", 121, P_EMG); lit("c122", 122, P_NSG);
    // Emergency pulse during yellow waits for yellow to finish.
    run_to(144); emg_req = 1'b1; step(); emg_req = 1'b0;
    lit("c145", 145, P_NSY); lit("c147", 147, P_NSY);
    lit("c148", 148, P_EMG); lit("c150", 150, P_EMG); lit("c151", 151, P_NSG);
    // Reset during east-west green with demand latched.
    ew_sense = 1'b1; step(); ew_sense = 1'b0;
    lit("c180", 180, P_EWG);
    run_to(183); ew_sense = 1'b1; step(); ew_sense = 1'b0;
    check("c184_phase", int'(phase), P_EWG);
    rst = 1'b1; step();
    check("rst_phase", int'(phase), P_INIT);
    check("rst_ns", int'(ns_light), 4);
    check("rst_ew", int'(ew_light), 4);
    check("rst_down", int'(tmr_down), 0);
    rst = 1'b0;
    cyc = 0;
    lit("r3", 3, P_AR2); lit("r4", 4, P_NSG);
    lit("r30", 30, P_AR1); lit("r33_dem_clear", 33, P_NSG);
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
